delay_line_mc: RTL and testbench

Parametrised multi-channel successor to the single-channel delay line. Each channel synchronises a 1-bit input, records every level transition as a timestamped entry in a per-channel edge FIFO, and replays each transition on its output exactly a programmable number of clock cycles later. Storing edges rather than samples means long delays cost no more than short ones: for example, 1 ms at 135 MHz, carrying 13.5 MHz-modulated pulse trains. It sits between the board input pins and the output/LED drivers.

---
 rtl/delay_line_mc.sv | 122 ++++++++++++
 tb/tb_delay_line_mc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_mc.sv
// delay_line_mc: multi-channel edge-timestamp delay line.
// Each channel synchronises its input and queues level transitions with a
// timestamp. Each transition is replayed on the output once its age equals
// the effective delay.
module delay_line_mc #(
  parameter int unsigned CHANNELS    = 1,
  parameter int unsigned CNT_W       = 18,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [CNT_W-1:0]    delay_cycles,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] active,
  output logic [CHANNELS-1:0] overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic             level;
    logic [CNT_W-1:0] stamp;
  } entry_t;

  logic [CNT_W-1:0]    now_q, now_d;
  logic [CNT_W-1:0]    delay_r_q, delay_r_d;
  logic [CHANNELS-1:0] empty_c;
  logic                all_empty_c;

  // Free-running timestamp counter and effective-delay selection.
  // The delay only reloads while nothing is queued, so every queued edge
  // sees the same delay.
  always_comb begin
    now_d       = now_q + CNT_W'(1);
    all_empty_c = &empty_c;
    delay_r_d   = delay_r_q;
    if (all_empty_c) begin
      delay_r_d = (delay_cycles < CNT_W'(2)) ? CNT_W'(2) : delay_cycles;
    end
  end

  // Shared counter and delay registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      now_q     <= '0;
      delay_r_q <= CNT_W'(2);
    end else begin
      now_q     <= now_d;
      delay_r_q <= delay_r_d;
    end
  end

  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   in_d_q;
    logic                   in_s_c;
    logic [PW-1:0]          wr_q, wr_d, rd_q, rd_d;
    entry_t                 mem_q [DEPTH];
    entry_t                 head_c;
    logic [CNT_W-1:0]       age_c;
    logic                   edge_c, full_c, pop_c, push_c, drop_c;
    logic                   out_q, out_d, act_q, act_d, ovf_q, ovf_d;

    // Edge detection, FIFO control and replay decision.
    // The stamp is the counter value at the push edge. The age reaches
    // delay_r at the edge that is exactly delay_r cycles after the push,
    // which gives the fixed SYNC_STAGES + delay_r input-to-output latency.
    always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], in[c]};
      in_s_c     = sync_q[SYNC_STAGES-1];
      edge_c     = in_s_c ^ in_d_q;
      empty_c[c] = (wr_q == rd_q);
      full_c     = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
      head_c     = mem_q[rd_q[AW-1:0]];
      age_c      = now_q - head_c.stamp;
      pop_c      = !empty_c[c] && (age_c == delay_r_q);
      push_c     = edge_c && (!full_c || pop_c);
      drop_c     = edge_c && full_c && !pop_c;
      wr_d       = wr_q + PW'(push_c);
      rd_d       = rd_q + PW'(pop_c);
      out_d      = pop_c ? head_c.level : out_q;
      act_d      = (wr_d != rd_d);
      ovf_d      = ovf_q | drop_c;
    end

    // Channel state registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
        in_d_q <= 1'b0;
        wr_q   <= '0;
        rd_q   <= '0;
        out_q  <= 1'b0;
        act_q  <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        sync_q <= sync_d;
        in_d_q <= in_s_c;
        wr_q   <= wr_d;
        rd_q   <= rd_d;
        out_q  <= out_d;
        act_q  <= act_d;
        ovf_q  <= ovf_d;
      end
    end

    // Edge storage. Reset needs no clearing because the pointers define validity.
    always_ff @(posedge clk_in) begin
      if (push_c) begin
        mem_q[wr_q[AW-1:0]] <= '{level: in_s_c, stamp: now_q};
      end
    end

    assign out[c]      = out_q;
    assign active[c]   = act_q;
    assign overflow[c] = ovf_q;
  end

endmodule

// File: tb/tb_delay_line_mc.sv
// Scoreboard bench for delay_line_mc (4 channels, 8-bit stamps, depth 8).
module tb_delay_line_mc;
  localparam int CH = 4;
  localparam int CW = 8;
  localparam int DP = 8;
  localparam int SS = 2;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b0;
  logic [CW-1:0] delay_cycles;
  logic [CH-1:0] in_v, out_v, active_v, overflow_v;

  delay_line_mc #(.CHANNELS(CH), .CNT_W(CW), .DEPTH(DP), .SYNC_STAGES(SS)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .delay_cycles(delay_cycles),
    .in(in_v), .out(out_v), .active(active_v), .overflow(overflow_v)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int push;
    int pop;
    bit lvl;
  } ev_t;

  ev_t           sb[$];
  logic [CH-1:0] exp_out = '0;
  int            ovf_at[CH];
  int            m_delay = 2;
  int            tests = 0;
  int            fails = 0;
  int            t0, t1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Entries of channel ch (any channel if ch<0) pushed before edge p and
  // still queued after edge p (incl: also those popped at edge p).
  function automatic int inflight(input int ch, input int p, input bit incl);
    int n = 0;
    foreach (sb[i]) begin
      if ((ch < 0 || sb[i].ch == ch) && sb[i].push < p &&
          (sb[i].pop > p || (incl && sb[i].pop == p))) n++;
    end
    return n;
  endfunction

  // Record an input level change made just after edge cyc.
  task automatic model_edge(input int c, input bit lvl);
    int p;
    p = cyc + 1 + SS;
    if (inflight(-1, p, 1'b1) == 0)
      m_delay = (delay_cycles < 2) ? 2 : int'(delay_cycles);
    if (inflight(c, p, 1'b0) >= DP) begin
      if (ovf_at[c] < 0) ovf_at[c] = p;
    end else begin
      sb.push_back('{ch: c, push: p, pop: p + m_delay, lvl: lvl});
    end
  endtask

  task automatic drive(input int c, input bit lvl);
    if (in_v[c] != lvl) begin
      in_v[c] = lvl;
      model_edge(c, lvl);
    end
  endtask

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic neg_at(input int n);
    while (cyc < n) @(negedge clk_in);
  endtask

  // Retire due scoreboard entries and compare all outputs each cycle.
  always @(negedge clk_in) begin
    logic [CH-1:0] exp_act;
    if (rst_n) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].pop <= cyc) begin
          exp_out[sb[i].ch] = sb[i].lvl;
          sb.delete(i);
        end
      end
      exp_act = '0;
      foreach (sb[i]) if (sb[i].push <= cyc) exp_act[sb[i].ch] = 1'b1;
      for (int c = 0; c < CH; c++) begin
        check($sformatf("out[%0d]", c), 32'(out_v[c]), 32'(exp_out[c]));
        check($sformatf("active[%0d]", c), 32'(active_v[c]), 32'(exp_act[c]));
        if (cyc != ovf_at[c])
          check($sformatf("overflow[%0d]", c), 32'(overflow_v[c]),
                32'(ovf_at[c] >= 0 && cyc > ovf_at[c]));
      end
    end
  end

  initial begin
    for (int c = 0; c < CH; c++) ovf_at[c] = -1;
    in_v         = 4'b1000;
    delay_cycles = 8'd10;
    rst_n        = 1'b0;
    #1;
    check("reset out", 32'(out_v), 32'h0);
    check("reset active", 32'(active_v), 32'h0);
    check("reset overflow", 32'(overflow_v), 32'h0);

    // Release with in[3] high: counts as a rising edge.
    step_to(3);
    rst_n = 1'b1;
    model_edge(3, 1'b1);
    step_to(20);
    drive(3, 1'b0);

    // Single pulse: first sampled at edge 100, delay 10 -> out high 112..118.
    step_to(99);
    drive(0, 1'b1);
    step_to(106);
    drive(0, 1'b0);
    neg_at(111); check("pulse pre", 32'(out_v[0]), 32'h0);
    neg_at(112); check("pulse start", 32'(out_v[0]), 32'h1);
    check("pulse active", 32'(active_v[0]), 32'h1);
    neg_at(118); check("pulse end", 32'(out_v[0]), 32'h1);
    neg_at(119); check("pulse post", 32'(out_v[0]), 32'h0);
    check("pulse overflow", 32'(overflow_v), 32'h0);

    // Modulated train (5 high / 5 low bursts) at delay 30.
    step_to(130);
    delay_cycles = 8'd30;
    step_to(140);
    for (int b = 0; b < 4; b++) begin
      for (int p = 0; p < 2; p++) begin
        drive(1, 1'b1); step_to(cyc + 5);
        drive(1, 1'b0); step_to(cyc + 5);
      end
      step_to(cyc + 10);
    end
    step_to(cyc + 50);
    check("train overflow", 32'(overflow_v), 32'h0);

    // Delay 0 clamps to 2; one-cycle pulse and gap.
    delay_cycles = 8'd0;
    step_to(cyc + 3);
    drive(1, 1'b1); step_to(cyc + 1);
    drive(1, 1'b0); step_to(cyc + 1);
    drive(1, 1'b1); step_to(cyc + 1);
    drive(1, 1'b0);
    step_to(cyc + 20);

    // Overflow on channel 2 only, other channels replay alongside.
    delay_cycles = 8'd100;
    step_to(cyc + 3);
    t0 = cyc;
    drive(1, 1'b1);
    for (int e = 0; e < 10; e++) begin
      drive(2, ~in_v[2]);
      if (e < 6) drive(0, ~in_v[0]);
      if (e < 4) drive(3, ~in_v[3]);
      step_to(cyc + 4);
    end
    drive(1, 1'b0);
    step_to(t0 + 160);
    check("ovf flags", 32'(overflow_v), 32'h4);
    check("ovf drained", 32'(active_v), 32'h0);

    // Wrap and delay change: in-flight pulse keeps 200, next uses 50.
    delay_cycles = 8'd200;
    step_to(cyc + 3);
    t1 = cyc;
    drive(0, 1'b1); step_to(cyc + 5);
    drive(0, 1'b0);
    step_to(t1 + 20);
    delay_cycles = 8'd50;
    neg_at(t1 + 3 + 199); check("d200 pre", 32'(out_v[0]), 32'h0);
    neg_at(t1 + 3 + 200); check("d200 edge", 32'(out_v[0]), 32'h1);
    step_to(t1 + 230);
    t1 = cyc;
    drive(0, 1'b1); step_to(cyc + 5);
    drive(0, 1'b0);
    neg_at(t1 + 3 + 49); check("d50 pre", 32'(out_v[0]), 32'h0);
    neg_at(t1 + 3 + 50); check("d50 edge", 32'(out_v[0]), 32'h1);
    step_to(t1 + 80);

    // Reset while edges are queued and one is replaying.
    delay_cycles = 8'd20;
    step_to(cyc + 3);
    t0 = cyc;
    drive(0, 1'b1);
    step_to(t0 + 10); drive(1, 1'b1);
    step_to(t0 + 15); drive(3, 1'b1);
    step_to(t0 + 20); drive(0, 1'b0);
    step_to(t0 + 25);
    rst_n = 1'b0;
    in_v  = '0;
    #1;
    check("midrst out", 32'(out_v), 32'h0);
    check("midrst active", 32'(active_v), 32'h0);
    check("midrst overflow", 32'(overflow_v), 32'h0);
    sb.delete();
    exp_out = '0;
    for (int c = 0; c < CH; c++) ovf_at[c] = -1;
    step_to(cyc + 3);
    rst_n = 1'b1;
    step_to(cyc + 150);
    check("final out", 32'(out_v), 32'h0);
    check("scoreboard empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
